// File: rtl/ans_tx_pkg.sv
// Shared types and defaults for the ANS transmit sequencing blocks.
// Holds the sequencer state encoding, the FIFO payload and the symbol-count clamp.
package ans_tx_pkg;

  localparam int unsigned SYM_LEN_DEF = 80;
  localparam int unsigned MAX_LTF_DEF = 4;
  localparam int unsigned SAMPLE_W    = 32;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned LTF_W       = 3;
  localparam int unsigned COEFF_W     = 128;

  typedef enum logic [2:0] {
    IDLE,
    BOOT,
    WAIT_BOOT,
    STREAM,
    DRAIN
  } seq_state_e;

  typedef struct packed {
    logic                last;
    logic [SAMPLE_W-1:0] data;
  } sample_t;

  // A zero count still produces one symbol; oversize requests saturate.
  function automatic logic [LTF_W-1:0] clamp_ltf(input logic [LTF_W-1:0] n,
                                                 input logic [LTF_W-1:0] max_ltf);
    logic [LTF_W-1:0] r;
    r = n;
    if (n == '0) r = LTF_W'(1);
    else if (n > max_ltf) r = max_ltf;
    return r;
  endfunction

endpackage

// File: rtl/ans_skid_fifo2.sv
// Two-entry output FIFO; entry 0 is always the head and drives the stream.
// Push and pop may occur in the same cycle; flush empties it synchronously.
module ans_skid_fifo2
  import ans_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush_i,
  input  logic       push_i,
  input  sample_t    push_data_i,
  input  logic       pop_i,
  output sample_t    head_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  sample_t    e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      e0_d  = '0;
      e1_d  = '0;
      cnt_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b01: begin
          e0_d  = e1_q;
          e1_d  = '0;
          cnt_d = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_data_i;
          else               e1_d = push_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = push_data_i;
          end else begin
            e0_d = e1_q;
            e1_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/ans_ht_ltf_seq.sv
// HT-LTF burst sequencer: boots the generator, walks its sample addresses and
// streams the returned samples downstream through a two-entry FIFO.
module ans_ht_ltf_seq
  import ans_tx_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 340,
  parameter int unsigned SYM_LEN     = SYM_LEN_DEF,
  parameter int unsigned MAX_LTF     = MAX_LTF_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [LTF_W-1:0]    num_ltf,
  input  logic [COEFF_W-1:0]  obf_coeff_in,
  input  logic                abort,
  output logic                gen_boot,
  output logic [ADDR_W-1:0]   gen_addr,
  output logic [COEFF_W-1:0]  gen_obf_coeff,
  input  logic [SAMPLE_W-1:0] gen_sample,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  seq_state_e         state_q, state_d;
  logic [BCW-1:0]     boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LTF_W-1:0]   sym_q, sym_d;
  logic [LTF_W-1:0]   nltf_q, nltf_d;
  logic [COEFF_W-1:0] coeff_q, coeff_d;
  logic               inflight_q, inflight_d;
  logic               infl_last_q, infl_last_d;
  logic               gen_boot_q, gen_boot_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  sample_t    fifo_head;
  sample_t    push_c;
  logic       fifo_valid;
  logic [1:0] fifo_cnt;
  logic       pop_c;
  logic       flush_c;
  logic [2:0] credit_c;
  logic       last_addr_c;
  logic       last_sym_c;

  assign pop_c       = fifo_valid && out_ready;
  assign flush_c     = abort && (state_q != IDLE);
  // Slots committed after this edge; counting the pop keeps back-to-back reads flowing.
  assign credit_c    = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop_c};
  assign last_addr_c = (addr_q == ADDR_W'(SYM_LEN - 1));
  assign last_sym_c  = (sym_q == nltf_q - LTF_W'(1));
  assign push_c.last = infl_last_q;
  assign push_c.data = gen_sample;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    addr_d      = addr_q;
    sym_d       = sym_q;
    nltf_d      = nltf_q;
    coeff_d     = coeff_q;
    inflight_d  = 1'b0;
    infl_last_d = 1'b0;
    gen_boot_d  = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = BOOT;
          nltf_d     = clamp_ltf(num_ltf, LTF_W'(MAX_LTF));
          coeff_d    = obf_coeff_in;
          addr_d     = '0;
          sym_d      = '0;
          boot_cnt_d = '0;
          gen_boot_d = 1'b1;
        end
      end
      BOOT: begin
        state_d    = WAIT_BOOT;
        boot_cnt_d = '0;
      end
      WAIT_BOOT: begin
        if (boot_cnt_q == BCW'(BOOT_CYCLES - 1)) state_d = STREAM;
        else boot_cnt_d = boot_cnt_q + BCW'(1);
      end
      STREAM: begin
        if (credit_c < 3'd2) begin
          inflight_d  = 1'b1;
          infl_last_d = last_addr_c && last_sym_c;
          if (last_addr_c && last_sym_c) begin
            state_d = DRAIN;
          end else if (last_addr_c) begin
            addr_d = '0;
            sym_d  = sym_q + LTF_W'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        // Leave on the edge that empties the pipe so done follows the last sample directly.
        if (!inflight_q && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop_c))) begin
          state_d = IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_c) begin
      state_d     = IDLE;
      inflight_d  = 1'b0;
      infl_last_d = 1'b0;
      addr_d      = '0;
      sym_d       = '0;
      boot_cnt_d  = '0;
      gen_boot_d  = 1'b0;
      done_d      = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      boot_cnt_q  <= '0;
      addr_q      <= '0;
      sym_q       <= '0;
      nltf_q      <= '0;
      coeff_q     <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      gen_boot_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      addr_q      <= addr_d;
      sym_q       <= sym_d;
      nltf_q      <= nltf_d;
      coeff_q     <= coeff_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      gen_boot_q  <= gen_boot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  ans_skid_fifo2 u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (flush_c),
    .push_i      (inflight_q),
    .push_data_i (push_c),
    .pop_i       (pop_c),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_cnt)
  );

  assign gen_boot      = gen_boot_q;
  assign gen_addr      = addr_q;
  assign gen_obf_coeff = coeff_q;
  assign out_data      = fifo_head.data;
  assign out_last      = fifo_head.last;
  assign out_valid     = fifo_valid;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/ans_ht_ltf_seq.md
ANS_HT_LTF_SEQ -- requirements
Module: ans_ht_ltf_seq

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 340: generator boot wait in clocks (1700 ns at 200 MHz).
REQ-002 SHALL have parameter SYM_LEN, default 80: samples per HT-LTF symbol.
REQ-003 SHALL have parameter MAX_LTF, default 4: maximum HT-LTF symbols per burst.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle burst request.
REQ-007 SHALL have port num_ltf  in  3  HT-LTF symbol count, sampled at start.
REQ-008 SHALL have port obf_coeff_in  in  128  obfuscation coefficients, sampled at start.
REQ-009 SHALL have port abort  in  1  synchronous cancel of the current burst.
REQ-010 SHALL have port gen_boot  out  1  boot pulse to the HT-LTF generator.
REQ-011 SHALL have port gen_addr  out  7  sample address to the generator.
REQ-012 SHALL have port gen_obf_coeff  out  128  latched coefficients to the generator.
REQ-013 SHALL have port gen_sample  in  32  generator sample, valid 1 clk after gen_addr.
REQ-014 SHALL have ports out_data (out, 32), out_valid (out, 1), out_ready (in, 1), out_last (out, 1): downstream valid/ready stream; out_last marks the final sample of the burst.
REQ-015 SHALL have ports busy (out, 1) and done (out, 1): burst active; one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, BOOT, WAIT_BOOT, STREAM, DRAIN.
REQ-017 IDLE->BOOT on start; num_ltf==0 treated as 1; num_ltf>MAX_LTF clamped to MAX_LTF; num_ltf and obf_coeff_in latched in that cycle.
REQ-018 BOOT SHALL last one cycle with gen_boot=1, then go to WAIT_BOOT.
REQ-019 WAIT_BOOT SHALL count exactly BOOT_CYCLES clocks, then go to STREAM with gen_addr=0.
REQ-020 STREAM SHALL issue a read (advance gen_addr) only when FIFO occupancy plus in-flight reads is < 2.
REQ-021 gen_addr SHALL wrap SYM_LEN-1 -> 0 and increment the symbol counter; after the last address of the last symbol, go to DRAIN.
REQ-022 Read data SHALL enter a 2-entry output FIFO one cycle after issue; the FIFO head drives out_data/out_valid.
REQ-023 A sample SHALL transfer only when out_valid && out_ready; out_data/out_last stay stable while out_valid && !out_ready.
REQ-024 out_last SHALL be 1 only on sample index num_ltf*SYM_LEN-1.
REQ-025 DRAIN->IDLE when the FIFO is empty and no read is in flight; done pulses 1 cycle on that transition.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start while busy SHALL be ignored; start and abort in the same cycle in IDLE SHALL be ignored.
REQ-028 abort in any non-IDLE state SHALL return to IDLE next cycle, flush FIFO and in-flight reads, deassert out_valid, and not pulse done.
REQ-029 Latency from start to first out_valid SHALL be BOOT_CYCLES+3 clocks with out_ready held 1.
REQ-030 With out_ready held 1, throughput SHALL be one sample per clock with no bubbles.

Reset
REQ-031 On rstn=0: state=IDLE, gen_boot=0, gen_addr=0, gen_obf_coeff=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, FIFO empty, counters 0.
REQ-032 Reset mid-burst SHALL discard the burst without a done pulse.

Structure
REQ-033 State encoding, SYM_LEN and MAX_LTF defaults SHALL live in shared package ans_tx_pkg.
REQ-034 The 2-entry FIFO SHALL be sub-module ans_skid_fifo2 (32+1 bits wide); the generator is instantiated outside this block.

Verification
REQ-035 num_ltf=1, out_ready=1 -> gen_boot pulse, first out_valid at BOOT_CYCLES+3, 80 samples, out_last on sample 79, done 1 cycle later.
REQ-036 num_ltf=4 -> 320 samples, gen_addr wraps 79->0 three times, out_last only on sample 319.
REQ-037 out_ready toggled 1010... -> 80 samples in order vs a generator model, no loss or duplication, data stable while stalled.
REQ-038 abort at sample 40 -> IDLE next cycle, out_valid=0, no done; new start then gives a full 80-sample burst.
REQ-039 num_ltf=0 and num_ltf=7 -> 80 and 320 samples respectively; start while busy has no effect.
REQ-040 rstn low during WAIT_BOOT -> all outputs at reset values asynchronously, no done pulse.
